sc_ifu: RTL and testbench
=========================

// Module: sc_ifu
// PURPOSE
//  Instruction-fetch unit upstream of the single-cycle control unit. Holds the PC
//  and fetches one word per instruction over a req/ack instruction-memory port.
//  Presents inst (op=inst[31:26], func=inst[5:0]) plus pc4 to decode/datapath.
//  Consumes the control unit's pcsource to form the next PC.
//  Flags bus timeout and misaligned targets.
// PARAMETERS
//  RESET_PC      32'h0000_0000  PC loaded on reset
//  TIMEOUT       16             max cycles in FETCH without imem_ack before error (>=2)
//  CNT_W         5              width of wait counter; must hold TIMEOUT
// PORTS
//  clock       in   1   single clock, all state on posedge
//  resetn      in   1   synchronous reset, active-low
//  imem_addr   out  32  fetch address, == pc
//  imem_req    out  1   fetch request, high only in FETCH
//  imem_ack    in   1   imem_rdata valid this cycle; honoured only in FETCH
//  imem_rdata  in   32  instruction word
//  inst        out  32  latched instruction, stable while inst_valid
//  inst_valid  out  1   inst is current; datapath executes this cycle
//  pc          out  32  address of inst
//  pc4         out  32  pc + 4 (jal link value)
//  pcsource    in   2   from control: 00 pc4, 01 branch, 10 jr, 11 j/jal
//  ra          in   32  register rs value, jr target
//  stall       in   1   hold current instruction in EXEC
//  fetch_err   out  1   sticky error; cleared only by reset
// BEHAVIOUR
//  Reset (resetn==0 at posedge): pc=RESET_PC, inst=0, inst_valid=0, fetch_err=0,
//   wait count=0, state=IDLE. imem_req=0. Reset wins over every other event.
//  States: IDLE, FETCH, EXEC, ERR (2-bit encoding).
//  IDLE: imem_req=0. Next cycle -> FETCH unconditionally.
//  FETCH: imem_req=1, imem_addr=pc.
//   imem_ack=1: inst<=imem_rdata, inst_valid<=1, count<=0, -> EXEC.
//   ack same cycle as req is legal.
//   no ack: count<=count+1; if count==TIMEOUT-1 -> ERR.
//  EXEC: inst_valid=1, imem_req=0; pcsource sampled here only.
//   stall=1: hold all state, pcsource/ra ignored.
//   stall=0: npc per pcsource; if npc[1:0]!=0 -> ERR, pc unchanged.
//   Otherwise pc<=npc, inst_valid<=0, -> FETCH.
//  ERR: fetch_err=1, imem_req=0, inst_valid=0; remain until reset.
//  npc arithmetic (32-bit, wraps mod 2^32, no overflow flag):
//   00: pc4.
//   01: pc4 + {{14{inst[15]}}, inst[15:0], 2'b00}.
//   10: ra.
//   11: {pc4[31:28], inst[25:0], 2'b00}.
//  Throughput: min 2 cycles/instruction (FETCH+EXEC); each wait cycle adds 1.
//  imem_ack outside FETCH ignored; reset mid-FETCH drops the request.
//  A late ack after reset is ignored, since state is IDLE.
//  pc 32'hFFFF_FFFC with pcsource 00 wraps to 0.
// STRUCTURE
//  Shared include sc_defs.vh: PCSRC_SEQ/BR/JR/J (2'b00..11); IFU state codes.
//  Sub-module sc_npc: combinational next-PC mux, inputs pc4/inst/ra/pcsource,
//   outputs npc and misalign flag.
//  FSM, wait counter, pc/inst registers stay in sc_ifu.
// TESTING
//  Reset then ack every FETCH, pcsource=00 -> imem_addr 0,4,8; inst_valid 1 of every 2 cycles.
//  pc=8, inst=32'h1000FFFF, pcsource=01 -> next imem_addr=32'h8 (pc4 0xC - 4).
//  pc=0, inst=32'h08000010, pcsource=11 -> next imem_addr=32'h40.
//  pcsource=10, ra=32'h102 -> fetch_err=1 next cycle, pc stays, imem_req stays 0.
//  Hold imem_ack=0 in FETCH -> ERR after exactly TIMEOUT cycles.
//  Ack on the last allowed cycle -> normal EXEC.
//  stall=1 for 3 EXEC cycles -> inst/pc unchanged, no req.
//  resetn low mid-FETCH then late ack -> pc=RESET_PC, ack ignored.

Source files
------------

// File: rtl/sc_ifu_pkg.sv
// Shared types and helpers for the single-cycle instruction-fetch unit.
// Next-PC select codes and IFU state encoding live here so decode and fetch agree.
package sc_ifu_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned IMM26_W = 26;
    localparam int unsigned IMM16_W = 16;

    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'b00,
        PCSRC_BR  = 2'b01,
        PCSRC_JR  = 2'b10,
        PCSRC_J   = 2'b11
    } pcsrc_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_ERR   = 2'b11
    } ifu_state_e;

    // Word-scaled, sign-extended branch displacement.
    function automatic logic [XLEN-1:0] br_offset(input logic [IMM16_W-1:0] imm16);
        return {{14{imm16[IMM16_W-1]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/sc_npc.sv
// Combinational next-PC select for the fetch unit.
// Flags any target that is not word aligned.
module sc_npc
    import sc_ifu_pkg::*;
(
    input  logic [XLEN-1:0]    pc4,
    input  logic [IMM26_W-1:0] imm26,
    input  logic [XLEN-1:0]    ra,
    input  logic [1:0]         pcsource,
    output logic [XLEN-1:0]    npc,
    output logic               misalign
);

    always_comb begin
        npc = pc4;
        unique case (pcsrc_e'(pcsource))
            PCSRC_SEQ: npc = pc4;
            PCSRC_BR:  npc = pc4 + br_offset(imm26[IMM16_W-1:0]);
            PCSRC_JR:  npc = ra;
            PCSRC_J:   npc = {pc4[XLEN-1:XLEN-4], imm26, 2'b00};
            default:   npc = pc4;
        endcase
        misalign = (npc[1:0] != 2'b00);
    end

endmodule

// File: rtl/sc_ifu.sv
// Instruction-fetch unit: holds the PC, fetches one word per instruction over
// a req/ack port, and advances the PC using the control unit's pcsource.
module sc_ifu
    import sc_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic            clock,
    input  logic            resetn,
    output logic [XLEN-1:0] imem_addr,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] inst,
    output logic            inst_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc4,
    input  logic [1:0]      pcsource,
    input  logic [XLEN-1:0] ra,
    input  logic            stall,
    output logic            fetch_err
);

    ifu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  pc4_q;
    logic [XLEN-1:0]  inst_q, inst_d;
    logic             valid_q, valid_d;
    logic             req_q, req_d;
    logic             err_q, err_d;
    logic [XLEN-1:0]  npc;
    logic             misalign;

    sc_npc u_npc (
        .pc4      (pc4_q),
        .imm26    (inst_q[IMM26_W-1:0]),
        .ra       (ra),
        .pcsource (pcsource),
        .npc      (npc),
        .misalign (misalign)
    );

    // State and datapath registers; reset overrides every other event.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pc_q    <= RESET_PC;
            pc4_q   <= RESET_PC + 32'd4;
            inst_q  <= '0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            pc4_q   <= pc_d + 32'd4;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            req_q   <= req_d;
            err_q   <= err_d;
        end
    end

    // Next-state and next-register values; outputs are decoded from state_d
    // so that every port is driven straight from a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        err_d   = err_q;

        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    inst_d  = imem_rdata;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_EXEC;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_EXEC: begin
                if (!stall) begin
                    if (misalign) begin
                        state_d = ST_ERR;
                    end else begin
                        pc_d    = npc;
                        valid_d = 1'b0;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_ERR;
            end
        endcase

        if (state_d == ST_ERR) begin
            err_d   = 1'b1;
            valid_d = 1'b0;
        end
        req_d = (state_d == ST_FETCH);
    end

    assign imem_addr  = pc_q;
    assign imem_req   = req_q;
    assign inst       = inst_q;
    assign inst_valid = valid_q;
    assign pc         = pc_q;
    assign pc4        = pc4_q;
    assign fetch_err  = err_q;

endmodule

// File: tb/tb_sc_ifu.sv
// Self-checking bench for sc_ifu: directed corner cases followed by random
// traffic, all checked against a transaction-level model of the fetch loop.
module tb_sc_ifu;

    localparam int unsigned TMO = 16;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int PH_IDLE = 0, PH_FETCH = 1, PH_EXEC = 2, PH_ERR = 3;

    logic        clock = 1'b0;
    logic        resetn;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [1:0]  pcsource;
    logic [31:0] ra;
    logic        stall;
    logic        fetch_err;

    int total = 0;
    int bad   = 0;

    // model state
    int          m_phase;
    int          m_wait;
    logic [31:0] m_pc;
    logic [31:0] m_inst;

    sc_ifu #(.RESET_PC(RST_PC), .TIMEOUT(TMO), .CNT_W(5)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .inst_valid (inst_valid),
        .pc         (pc),
        .pc4        (pc4),
        .pcsource   (pcsource),
        .ra         (ra),
        .stall      (stall),
        .fetch_err  (fetch_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] target(input logic [1:0] sel, input logic [31:0] cur_pc,
                                           input logic [31:0] word, input logic [31:0] rav);
        logic [31:0] nxt;
        int          disp;
        nxt = cur_pc + 32'd4;
        case (sel)
            2'd1: begin
                disp = int'($signed(word[15:0])) * 4;
                return nxt + 32'(disp);
            end
            2'd2:    return rav;
            2'd3:    return (nxt & 32'hF000_0000) | (32'(word[25:0]) << 2);
            default: return nxt;
        endcase
    endfunction

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        logic [31:0] t;
        if (!resetn) begin
            m_phase = PH_IDLE; m_pc = RST_PC; m_inst = '0; m_wait = 0;
            return;
        end
        case (m_phase)
            PH_IDLE: m_phase = PH_FETCH;
            PH_FETCH: begin
                if (imem_ack) begin
                    m_inst = imem_rdata; m_wait = 0; m_phase = PH_EXEC;
                end else begin
                    m_wait++;
                    if (m_wait == int'(TMO)) m_phase = PH_ERR;
                end
            end
            PH_EXEC: begin
                if (!stall) begin
                    t = target(pcsource, m_pc, m_inst, ra);
                    if (t % 4 != 0) m_phase = PH_ERR;
                    else begin m_pc = t; m_phase = PH_FETCH; end
                end
            end
            default: m_phase = PH_ERR;
        endcase
    endtask

    task automatic compare_all();
        check("imem_req",   32'(imem_req),   32'(m_phase == PH_FETCH));
        check("imem_addr",  imem_addr,       m_pc);
        check("pc",         pc,              m_pc);
        check("pc4",        pc4,             m_pc + 32'd4);
        check("inst_valid", 32'(inst_valid), 32'(m_phase == PH_EXEC));
        check("fetch_err",  32'(fetch_err),  32'(m_phase == PH_ERR));
        if (m_phase == PH_EXEC) check("inst", inst, m_inst);
        if (m_phase == PH_IDLE) check("inst_rst", inst, 32'h0);
    endtask

    // One clock: drive inputs, step model at the edge, compare at the falling edge.
    task automatic cycle(input logic rst, input logic ack, input logic [31:0] rdata,
                         input logic [1:0] sel, input logic [31:0] rav, input logic stl);
        resetn = rst; imem_ack = ack; imem_rdata = rdata;
        pcsource = sel; ra = rav; stall = stl;
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare_all();
    endtask

    initial begin
        logic [31:0] rv;
        resetn = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        pcsource = 2'd0; ra = '0; stall = 1'b0;
        m_phase = PH_IDLE; m_pc = RST_PC; m_inst = '0; m_wait = 0;

        // reset state
        cycle(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_pc", pc, RST_PC);

        // sequential fetch 0,4,8
        cycle(1, 0, 0, 0, 0, 0);
        check("seq_addr0", imem_addr, 32'h0);
        cycle(1, 1, 32'h0000_0020, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        check("seq_addr4", imem_addr, 32'h4);
        cycle(1, 1, 32'h0000_0020, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        check("seq_addr8", imem_addr, 32'h8);

        // backward branch from pc=8
        cycle(1, 1, 32'h1000_FFFF, 0, 0, 0);
        cycle(1, 0, 0, 2'b01, 0, 0);
        check("br_addr", imem_addr, 32'h8);

        // jump from pc=0
        cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 1, 32'h0800_0010, 0, 0, 0);
        cycle(1, 0, 0, 2'b11, 0, 0);
        check("j_addr", imem_addr, 32'h40);

        // jr to the top word, then sequential wrap to 0
        cycle(1, 1, 32'h0, 0, 0, 0);
        cycle(1, 0, 0, 2'b10, 32'hFFFF_FFFC, 0);
        check("jr_top", imem_addr, 32'hFFFF_FFFC);
        cycle(1, 1, 32'h0, 0, 0, 0);
        cycle(1, 0, 0, 2'b00, 0, 0);
        check("wrap", imem_addr, 32'h0);

        // stall holds the instruction for three cycles
        cycle(1, 1, 32'h0000_1234, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 32'h5555_5555, 2'b10, 32'h0000_0102, 1);
            check("stall_inst", inst, 32'h0000_1234);
            check("stall_req", 32'(imem_req), 32'h0);
        end
        cycle(1, 0, 0, 2'b00, 0, 0);
        check("post_stall", imem_addr, 32'h4);

        // misaligned jr target
        cycle(1, 1, 32'h0, 0, 0, 0);
        cycle(1, 0, 0, 2'b10, 32'h0000_0102, 0);
        check("jr_err", 32'(fetch_err), 32'h1);
        check("jr_pc", pc, 32'h4);
        cycle(1, 1, 32'h0, 0, 0, 0);
        check("err_sticky", 32'(fetch_err), 32'h1);

        // timeout after exactly TMO wait cycles
        cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < int'(TMO) - 1; i++) cycle(1, 0, 0, 0, 0, 0);
        check("tmo_early", 32'(fetch_err), 32'h0);
        cycle(1, 0, 0, 0, 0, 0);
        check("tmo_err", 32'(fetch_err), 32'h1);

        // ack on the last allowed cycle
        cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < int'(TMO) - 1; i++) cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 1, 32'hCAFE_0000, 0, 0, 0);
        check("late_ok_valid", 32'(inst_valid), 32'h1);
        check("late_ok_err", 32'(fetch_err), 32'h0);

        // reset mid-fetch, then a stale ack
        cycle(1, 0, 0, 2'b00, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 1, 32'hBAD0_0000, 0, 0, 0);
        check("stale_pc", pc, RST_PC);
        check("stale_valid", 32'(inst_valid), 32'h0);
        check("stale_inst", inst, 32'h0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rv = $urandom;
            if (m_phase == PH_ERR || $urandom_range(0, 199) == 0)
                cycle(0, 1'($urandom), rv, 2'($urandom), rv, 1'($urandom));
            else
                cycle(1, $urandom_range(0, 9) < 7, rv, 2'($urandom),
                      ($urandom_range(0, 9) < 9) ? {rv[31:2], 2'b00} : rv,
                      $urandom_range(0, 9) < 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
